// File: rtl/my_dsp48a1.sv
// my_dsp48a1: behavioural Spartan-6 DSP48A1 slice (pre-adder, 18x18 multiplier, 48-bit post-adder).
// Each pipeline stage is a parameter-selectable register with its own synchronous reset and CE.
module my_dsp48a1 #(
   parameter int unsigned A0REG       = 0,
   parameter int unsigned A1REG       = 1,
   parameter int unsigned B0REG       = 0,
   parameter int unsigned B1REG       = 1,
   parameter int unsigned CREG        = 1,
   parameter int unsigned DREG        = 1,
   parameter int unsigned MREG        = 1,
   parameter int unsigned PREG        = 1,
   parameter int unsigned OPMODEREG   = 1,
   parameter int unsigned CARRYINREG  = 1,
   parameter int unsigned CARRYOUTREG = 1,
   parameter string       CARRYINSEL  = "OPMODE5",
   parameter string       B_INPUT     = "DIRECT",
   parameter string       RSTTYPE     = "SYNC"
) (
   input  logic        clk_i,
   input  logic        rsta_i,
   input  logic        rstb_i,
   input  logic        rstc_i,
   input  logic        rstd_i,
   input  logic        rstm_i,
   input  logic        rstp_i,
   input  logic        rstcarryin_i,
   input  logic        rstopmode_i,
   input  logic        cea_i,
   input  logic        ceb_i,
   input  logic        cec_i,
   input  logic        ced_i,
   input  logic        cem_i,
   input  logic        cep_i,
   input  logic        cecarryin_i,
   input  logic        ceopmode_i,
   input  logic [17:0] a_i,
   input  logic [17:0] b_i,
   input  logic [17:0] bcin_i,
   input  logic [17:0] d_i,
   input  logic [47:0] c_i,
   input  logic [47:0] pcin_i,
   input  logic        carryin_i,
   input  logic [7:0]  opmode_i,
   output logic [17:0] bcout_o,
   output logic [35:0] m_o,
   output logic [47:0] p_o,
   output logic [47:0] pcout_o,
   output logic        carryout_o,
   output logic        carryoutf_o
);

   // Unrecognised string parameters select a constant zero source.
   localparam int unsigned BSel   = (B_INPUT == "DIRECT") ? 1 : (B_INPUT == "CASCADE") ? 2 : 0;
   localparam int unsigned CinSel = (CARRYINSEL == "OPMODE5") ? 1 :
                                    (CARRYINSEL == "CARRYIN") ? 2 : 0;

   // ---------------- stage 0 ----------------
   logic [17:0] b_src;
   logic [17:0] a0_q, b0_q, d0_q;
   logic [17:0] a0, b0, d0;
   logic [47:0] c0_q, c0;
   logic [7:0]  op_q, op;

   always_comb begin
      b_src = '0;
      if (BSel == 1) b_src = b_i;
      else if (BSel == 2) b_src = bcin_i;
   end

   always_ff @(posedge clk_i) begin
      if (rsta_i) a0_q <= '0;
      else if (cea_i) a0_q <= a_i;
   end

   always_ff @(posedge clk_i) begin
      if (rstb_i) b0_q <= '0;
      else if (ceb_i) b0_q <= b_src;
   end

   always_ff @(posedge clk_i) begin
      if (rstd_i) d0_q <= '0;
      else if (ced_i) d0_q <= d_i;
   end

   always_ff @(posedge clk_i) begin
      if (rstc_i) c0_q <= '0;
      else if (cec_i) c0_q <= c_i;
   end

   always_ff @(posedge clk_i) begin
      if (rstopmode_i) op_q <= '0;
      else if (ceopmode_i) op_q <= opmode_i;
   end

   assign a0 = (A0REG != 0)     ? a0_q : a_i;
   assign b0 = (B0REG != 0)     ? b0_q : b_src;
   assign d0 = (DREG != 0)      ? d0_q : d_i;
   assign c0 = (CREG != 0)      ? c0_q : c_i;
   assign op = (OPMODEREG != 0) ? op_q : opmode_i;

   // ---------------- pre-adder and stage 1 ----------------
   logic [17:0] pre;
   logic [17:0] b1_d, b1_q, b1;
   logic [17:0] a1_q, a1;

   assign pre  = op[6] ? (d0 - b0) : (d0 + b0);
   assign b1_d = op[4] ? pre : b0;

   always_ff @(posedge clk_i) begin
      if (rstb_i) b1_q <= '0;
      else if (ceb_i) b1_q <= b1_d;
   end

   always_ff @(posedge clk_i) begin
      if (rsta_i) a1_q <= '0;
      else if (cea_i) a1_q <= a0;
   end

   assign b1 = (B1REG != 0) ? b1_q : b1_d;
   assign a1 = (A1REG != 0) ? a1_q : a0;

   // ---------------- multiplier ----------------
   logic [35:0] m_d, m_q, m;

   assign m_d = 36'(b1) * 36'(a1);

   always_ff @(posedge clk_i) begin
      if (rstm_i) m_q <= '0;
      else if (cem_i) m_q <= m_d;
   end

   assign m = (MREG != 0) ? m_q : m_d;

   // ---------------- carry-in ----------------
   logic cin_d, cin_q, cin;

   always_comb begin
      cin_d = 1'b0;
      if (CinSel == 1) cin_d = op[5];
      else if (CinSel == 2) cin_d = carryin_i;
   end

   always_ff @(posedge clk_i) begin
      if (rstcarryin_i) cin_q <= 1'b0;
      else if (cecarryin_i) cin_q <= cin_d;
   end

   assign cin = (CARRYINREG != 0) ? cin_q : cin_d;

   // ---------------- X / Z muxes and post-adder ----------------
   logic [47:0] x_mux, z_mux;
   logic [47:0] p;
   logic [48:0] x_cin;
   logic [48:0] sum;

   always_comb begin
      x_mux = '0;
      unique case (op[1:0])
         2'd0: x_mux = '0;
         2'd1: x_mux = {12'd0, m};
         2'd2: x_mux = p;
         2'd3: x_mux = {d0[11:0], a1, b1};
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      unique case (op[3:2])
         2'd0: z_mux = '0;
         2'd1: z_mux = pcin_i;
         2'd2: z_mux = p;
         2'd3: z_mux = c0;
         default: z_mux = '0;
      endcase
   end

   // Bit 48 is the carry when adding and the borrow when subtracting.
   assign x_cin = {1'b0, x_mux} + 49'(cin);
   assign sum   = op[7] ? ({1'b0, z_mux} - x_cin) : ({1'b0, z_mux} + x_cin);

   // ---------------- output stage ----------------
   logic [47:0] p_q;
   logic        cout_q, cout;

   always_ff @(posedge clk_i) begin
      if (rstp_i) p_q <= '0;
      else if (cep_i) p_q <= sum[47:0];
   end

   always_ff @(posedge clk_i) begin
      if (rstcarryin_i) cout_q <= 1'b0;
      else if (cecarryin_i) cout_q <= sum[48];
   end

   assign p    = (PREG != 0) ? p_q : sum[47:0];
   assign cout = (CARRYOUTREG != 0) ? cout_q : sum[48];

   assign bcout_o     = b1;
   assign m_o         = m;
   assign p_o         = p;
   assign pcout_o     = p;
   assign carryout_o  = cout;
   assign carryoutf_o = cout;

endmodule

// File: tb/tb_my_dsp48a1.sv
// tb_my_dsp48a1: directed checks of documented vectors plus randomized CE/RST traffic
// compared cycle by cycle against a behavioural model of the default-parameter slice.
module tb_my_dsp48a1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;
   logic        cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode;
   logic [17:0] a, b, bcin, d;
   logic [47:0] c, pcin;
   logic        carryin;
   logic [7:0]  opmode;
   logic [17:0] bcout;
   logic [35:0] m;
   logic [47:0] p, pcout;
   logic        carryout, carryoutf;

   int n_vec = 0;
   int n_err = 0;

   // Model state: the values each default-configuration pipeline stage holds.
   logic [17:0] s_a1, s_b1, s_d0;
   logic [47:0] s_c0, s_p;
   logic [35:0] s_m;
   logic [7:0]  s_op;
   logic        s_cin, s_cout;

   my_dsp48a1 dut (
      .clk_i        (clk),
      .rsta_i       (rsta),
      .rstb_i       (rstb),
      .rstc_i       (rstc),
      .rstd_i       (rstd),
      .rstm_i       (rstm),
      .rstp_i       (rstp),
      .rstcarryin_i (rstcarryin),
      .rstopmode_i  (rstopmode),
      .cea_i        (cea),
      .ceb_i        (ceb),
      .cec_i        (cec),
      .ced_i        (ced),
      .cem_i        (cem),
      .cep_i        (cep),
      .cecarryin_i  (cecarryin),
      .ceopmode_i   (ceopmode),
      .a_i          (a),
      .b_i          (b),
      .bcin_i       (bcin),
      .d_i          (d),
      .c_i          (c),
      .pcin_i       (pcin),
      .carryin_i    (carryin),
      .opmode_i     (opmode),
      .bcout_o      (bcout),
      .m_o          (m),
      .p_o          (p),
      .pcout_o      (pcout),
      .carryout_o   (carryout),
      .carryoutf_o  (carryoutf)
   );

   task automatic set_ctrl(input logic rst_all, input logic ce_all);
      {rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode} = {8{rst_all}};
      {cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode} = {8{ce_all}};
   endtask

   task automatic set_data(input logic [17:0] av, input logic [17:0] bv, input logic [17:0] dv,
                           input logic [47:0] cv, input logic [47:0] pv, input logic [7:0] ov);
      a = av; b = bv; d = dv; c = cv; pcin = pv; opmode = ov;
      bcin = 18'h2AAAA; carryin = 1'b1;
   endtask

   // Advance the model by one rising edge from the current inputs, then let the DUT take it.
   task automatic step();
      logic [17:0] pre, b1_in;
      logic [47:0] x, z;
      logic [48:0] total, addend;
      pre   = s_op[6] ? 18'(s_d0 - b) : 18'(s_d0 + b);
      b1_in = s_op[4] ? pre : b;
      case (s_op[1:0])
         2'd0: x = 48'd0;
         2'd1: x = {12'd0, s_m};
         2'd2: x = s_p;
         default: x = {s_d0[11:0], s_a1, s_b1};
      endcase
      case (s_op[3:2])
         2'd0: z = 48'd0;
         2'd1: z = pcin;
         2'd2: z = s_p;
         default: z = s_c0;
      endcase
      addend = 49'(x) + 49'(s_cin);
      total  = s_op[7] ? 49'(z) - addend : 49'(z) + addend;
      if (rstm) s_m = '0; else if (cem) s_m = 36'(s_b1) * 36'(s_a1);
      if (rstp) s_p = '0; else if (cep) s_p = total[47:0];
      if (rstcarryin) begin
         s_cin = 1'b0; s_cout = 1'b0;
      end else if (cecarryin) begin
         s_cin = s_op[5]; s_cout = total[48];
      end
      if (rstb) s_b1 = '0; else if (ceb) s_b1 = b1_in;
      if (rsta) s_a1 = '0; else if (cea) s_a1 = a;
      if (rstd) s_d0 = '0; else if (ced) s_d0 = d;
      if (rstc) s_c0 = '0; else if (cec) s_c0 = c;
      if (rstopmode) s_op = '0; else if (ceopmode) s_op = opmode;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_ctrl(1'b1, 1'b1);
      set_data(18'h3FFFF, 18'h12345, 18'h0ABCD, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 8'hFF);
      step();
      n_vec++;
      if (bcout !== 18'd0) begin n_err++; $display("FAIL reset_bcout got %h want 0", bcout); end
      n_vec++;
      if (m !== 36'd0) begin n_err++; $display("FAIL reset_m got %h want 0", m); end
      n_vec++;
      if (p !== 48'd0) begin n_err++; $display("FAIL reset_p got %h want 0", p); end
      n_vec++;
      if (pcout !== 48'd0) begin n_err++; $display("FAIL reset_pcout got %h want 0", pcout); end
      n_vec++;
      if ({carryout, carryoutf} !== 2'b00) begin
         n_err++; $display("FAIL reset_carry got %b%b want 00", carryout, carryoutf);
      end
      set_ctrl(1'b0, 1'b1);
   endtask

   task automatic test_mult();
      set_data(18'd5, 18'd7, 18'd0, 48'd0, 48'd0, 8'h01);
      repeat (3) step();
      n_vec++;
      if (m !== 36'd35) begin n_err++; $display("FAIL mult_m got %0d want 35", m); end
      n_vec++;
      if (p !== 48'd35 || pcout !== 48'd35) begin
         n_err++; $display("FAIL mult_p got %0d/%0d want 35", p, pcout);
      end
      n_vec++;
      if (bcout !== 18'd7 || carryout !== 1'b0) begin
         n_err++; $display("FAIL mult_bcout got %h,%b want 7,0", bcout, carryout);
      end
   endtask

   task automatic test_preadd();
      set_data(18'h32, 18'hB, 18'h10, 48'd0, 48'd0, 8'h10);
      repeat (4) step();
      n_vec++;
      if (bcout !== 18'h1B) begin n_err++; $display("FAIL preadd_bcout got %h want 1b", bcout); end
      n_vec++;
      if (m !== 36'h546) begin n_err++; $display("FAIL preadd_m got %h want 546", m); end
      n_vec++;
      if (p !== 48'd0) begin n_err++; $display("FAIL preadd_p got %h want 0", p); end
   endtask

   task automatic test_pcin();
      set_data(18'd0, 18'd0, 18'd0, 48'd0, 48'h13, 8'h04);
      repeat (3) step();
      n_vec++;
      if (p !== 48'h13 || pcout !== 48'h13) begin
         n_err++; $display("FAIL pcin_p got %h/%h want 13", p, pcout);
      end
   endtask

   task automatic test_carryin();
      set_data(18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 8'h20);
      repeat (3) step();
      n_vec++;
      if (p !== 48'd1 || carryout !== 1'b0) begin
         n_err++; $display("FAIL cin_p got %h,%b want 1,0", p, carryout);
      end
   endtask

   task automatic test_subtract();
      set_data(18'd1, 18'd1, 18'd1, 48'd0, 48'hF, 8'hF5);
      repeat (4) step();
      n_vec++;
      if (bcout !== 18'd0 || m !== 36'd0) begin
         n_err++; $display("FAIL sub_bm got %h,%h want 0,0", bcout, m);
      end
      n_vec++;
      if (p !== 48'hE || carryout !== 1'b0) begin
         n_err++; $display("FAIL sub_p got %h,%b want e,0", p, carryout);
      end
   endtask

   // 0 - (0 + 1) borrows; all-ones C + carry wraps to 0 with carry out.
   task automatic test_wrap();
      set_data(18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 8'hA4);
      repeat (4) step();
      n_vec++;
      if (p !== 48'hFFFF_FFFF_FFFF || carryout !== 1'b1 || carryoutf !== 1'b1) begin
         n_err++; $display("FAIL borrow got %h,%b want ffffffffffff,1", p, carryout);
      end
      set_data(18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 8'h2C);
      repeat (4) step();
      n_vec++;
      if (p !== 48'd0 || carryout !== 1'b1) begin
         n_err++; $display("FAIL carry_wrap got %h,%b want 0,1", p, carryout);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         a       = ($urandom_range(3) == 0) ? 18'h3FFFF : 18'($urandom);
         b       = ($urandom_range(3) == 0) ? 18'h3FFFF : 18'($urandom);
         d       = 18'($urandom);
         bcin    = 18'($urandom);
         c       = {16'($urandom), 32'($urandom)};
         pcin    = {16'($urandom), 32'($urandom)};
         carryin = 1'($urandom);
         opmode  = 8'($urandom);
         {cea, ceb, cec, ced} = {$urandom_range(3) != 0, $urandom_range(3) != 0,
                                 $urandom_range(3) != 0, $urandom_range(3) != 0};
         {cem, cep, cecarryin, ceopmode} = {$urandom_range(3) != 0, $urandom_range(3) != 0,
                                            $urandom_range(3) != 0, $urandom_range(3) != 0};
         {rsta, rstb, rstc, rstd} = {$urandom_range(15) == 0, $urandom_range(15) == 0,
                                     $urandom_range(15) == 0, $urandom_range(15) == 0};
         {rstm, rstp, rstcarryin, rstopmode} = {$urandom_range(15) == 0, $urandom_range(15) == 0,
                                                $urandom_range(15) == 0, $urandom_range(15) == 0};
         step();
         n_vec++;
         if (bcout !== s_b1) begin
            n_err++; $display("FAIL rand_bcout cycle %0d got %h want %h", i, bcout, s_b1);
         end
         n_vec++;
         if (m !== s_m) begin
            n_err++; $display("FAIL rand_m cycle %0d got %h want %h", i, m, s_m);
         end
         n_vec++;
         if (p !== s_p || pcout !== s_p) begin
            n_err++; $display("FAIL rand_p cycle %0d got %h/%h want %h", i, p, pcout, s_p);
         end
         n_vec++;
         if (carryout !== s_cout || carryoutf !== s_cout) begin
            n_err++;
            $display("FAIL rand_carry cycle %0d got %b%b want %b", i, carryout, carryoutf, s_cout);
         end
      end
      set_ctrl(1'b0, 1'b1);
   endtask

   initial begin
      set_ctrl(1'b1, 1'b1);
      set_data(18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 8'h00);
      @(posedge clk);
      #1;
      test_reset();
      test_mult();
      test_preadd();
      test_pcin();
      test_carryin();
      test_subtract();
      test_wrap();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
